// File: rtl/column_frame_buffer.sv
// column_frame_buffer: double-buffered per-column distance/texture store; banks swap on the v_sync fall after a commit.
module column_frame_buffer #(
  parameter int COLUMNS = 320,
  parameter int ADDR_WIDTH = 9,
  parameter logic [15:0] DEFAULT_DISTANCE = 16'hFFFF,
  parameter logic [15:0] DEFAULT_TEXTURE = 16'h0000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [15:0]           wr_distance,
  input  logic [15:0]           wr_texture,
  input  logic                  commit,
  output logic                  wr_ready,
  output logic                  swap_pending,
  output logic                  swap_done,
  input  logic                  v_sync,
  input  logic [ADDR_WIDTH-1:0] reading_index,
  output logic [15:0]           distance,
  output logic [15:0]           texture
);
  typedef enum logic {FILL, WAIT} state_t;
  localparam logic [ADDR_WIDTH:0] LIMIT = COLUMNS[ADDR_WIDTH:0];
  state_t state_q, state_d;
  logic front_q, v_sync_q, swap_done_q;
  logic [15:0] distance_q, texture_q;
  logic [31:0] bank0 [COLUMNS];
  logic [31:0] bank1 [COLUMNS];
  logic fall, swap, wr_ok, rd_ok;
  assign fall = v_sync_q & ~v_sync;
  assign swap = fall & (state_q == WAIT);
  assign wr_ok = wr_en & (state_q == FILL) & ({1'b0, wr_addr} < LIMIT);
  assign rd_ok = {1'b0, reading_index} < LIMIT;
  always_ff @(posedge clk or negedge clr)
    if (!clr) state_q <= FILL;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == FILL && commit) state_d = WAIT;
    if (swap) state_d = FILL;
  end
  always_comb begin
    wr_ready = state_q == FILL;
    swap_pending = state_q == WAIT;
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      front_q <= 1'b0;
      v_sync_q <= 1'b1;
      swap_done_q <= 1'b0;
    end else begin
      front_q <= front_q ^ swap;
      v_sync_q <= v_sync;
      swap_done_q <= swap;
    end
  // Back bank is always the one the GPU is not reading, so no read/write collision.
  always_ff @(posedge clk)
    if (wr_ok) begin
      if (front_q) bank0[wr_addr] <= {wr_distance, wr_texture};
      else bank1[wr_addr] <= {wr_distance, wr_texture};
    end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      distance_q <= DEFAULT_DISTANCE;
      texture_q <= DEFAULT_TEXTURE;
    end else if (!rd_ok) begin
      distance_q <= DEFAULT_DISTANCE;
      texture_q <= DEFAULT_TEXTURE;
    end else begin
      {distance_q, texture_q} <= front_q ? bank1[reading_index] : bank0[reading_index];
    end
  assign swap_done = swap_done_q;
  assign distance = distance_q;
  assign texture = texture_q;
endmodule
